// File: rtl/x_oserdes_gen.sv
// x_oserdes_gen: parametrised SDR output serializer.
// A holding register backs a per-lane shift register so consecutive words
// stream out with no gap. All lanes share one counter, one FSM and one
// tristate control. Lanes differ only in the data they carry.
module x_oserdes_gen #(
  parameter int   DATA_WIDTH  = 8,
  parameter int   LANES       = 1,
  parameter bit   MSB_FIRST   = 1'b0,
  parameter logic INIT_OQ     = 1'b0,
  parameter logic SRVAL_TQ    = 1'b1,
  parameter bit   TRISTATE_EN = 1'b1
) (
  input  logic                        CLK,
  input  logic                        SR,
  input  logic [LANES*DATA_WIDTH-1:0] D,
  input  logic                        D_VALID,
  output logic                        D_READY,
  input  logic                        OCE,
  output logic [LANES-1:0]            OQ,
  output logic                        TQ,
  output logic                        BUSY,
  output logic                        UNDERRUN
);

  localparam int              CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DATA_WIDTH);
  // When tristating is disabled the pad is driven all the time.
  localparam logic            TQ_IDLE  = TRISTATE_EN ? SRVAL_TQ : 1'b0;

  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_SHIFT = 1'b1;

  logic [LANES*DATA_WIDTH-1:0] hold_reg;
  logic                        hold_full_reg;
  logic [CW-1:0]               cnt_reg;
  logic [0:0]                  state_reg;
  logic                        tq_reg;
  logic                        underrun_reg;

  logic accept;
  logic at_boundary;
  logic do_load;
  logic do_shift;
  logic do_stop;

  // Holding register is writable only when empty, so an accept and a reload
  // can never happen at the same edge.
  assign accept      = D_VALID & ~hold_full_reg;
  // Last bit of the current word is on OQ; this edge decides reload or stop.
  assign at_boundary = (state_reg == ST_SHIFT) && (cnt_reg == LAST_CNT);
  assign do_load     = OCE & hold_full_reg & ((state_reg == ST_IDLE) | at_boundary);
  assign do_shift    = OCE & (state_reg == ST_SHIFT) & ~at_boundary;
  assign do_stop     = OCE & at_boundary & ~hold_full_reg;

  assign D_READY  = ~hold_full_reg;
  assign TQ       = tq_reg;
  assign BUSY     = (state_reg == ST_SHIFT);
  assign UNDERRUN = underrun_reg;

  // Capture the parallel word; its contents only matter while hold_full is set.
  always_ff @(posedge CLK) begin
    if (accept) begin
      hold_reg <= D;
    end
  end

  // Shared control path: holding flag, FSM, bit counter, tristate, underrun.
  always_ff @(posedge CLK or posedge SR) begin
    if (SR) begin
      hold_full_reg <= 1'b0;
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      tq_reg        <= TQ_IDLE;
      underrun_reg  <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;
      if (do_load) begin
        hold_full_reg <= 1'b0;
        state_reg     <= ST_SHIFT;
        cnt_reg       <= CW'(1);
        tq_reg        <= 1'b0;
      end else begin
        if (accept) begin
          hold_full_reg <= 1'b1;
        end
        if (do_shift) begin
          cnt_reg <= cnt_reg + CW'(1);
        end else if (do_stop) begin
          state_reg    <= ST_IDLE;
          cnt_reg      <= '0;
          tq_reg       <= TQ_IDLE;
          underrun_reg <= 1'b1;
        end
      end
    end
  end

  // Per-lane data path: the first bit goes straight to OQ on load and the
  // remaining bits wait in the shifter, already aligned for the next shift.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] load_shift;
    logic [DATA_WIDTH-1:0] run_shift;
    logic                  load_bit;
    logic                  run_bit;
    logic                  oq_bit_reg;

    assign word = hold_reg[gi*DATA_WIDTH +: DATA_WIDTH];

    if (MSB_FIRST) begin : g_msb
      assign load_bit   = word[DATA_WIDTH-1];
      assign load_shift = {word[DATA_WIDTH-2:0], 1'b0};
      assign run_bit    = shift_reg[DATA_WIDTH-1];
      assign run_shift  = {shift_reg[DATA_WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign load_bit   = word[0];
      assign load_shift = {1'b0, word[DATA_WIDTH-1:1]};
      assign run_bit    = shift_reg[0];
      assign run_shift  = {1'b0, shift_reg[DATA_WIDTH-1:1]};
    end

    // Serial output register and shifter for this lane.
    always_ff @(posedge CLK or posedge SR) begin
      if (SR) begin
        shift_reg  <= '0;
        oq_bit_reg <= INIT_OQ;
      end else if (do_load) begin
        shift_reg  <= load_shift;
        oq_bit_reg <= load_bit;
      end else if (do_shift) begin
        shift_reg  <= run_shift;
        oq_bit_reg <= run_bit;
      end else if (do_stop) begin
        oq_bit_reg <= INIT_OQ;
      end
    end

    assign OQ[gi] = oq_bit_reg;
  end

endmodule

// File: tb/tb_x_oserdes_gen.sv
// Testbench for x_oserdes_gen: two instances (2-lane LSB-first, 1-lane
// MSB-first) sharing clock, reset and OCE. Directed scenarios plus a random
// stream checked against a word-schedule model.
module tb_x_oserdes_gen;

  localparam int DW   = 8;
  localparam int NCYC = 300;
  localparam int NDRV = 280;

  logic        clk;
  logic        sr;
  logic        oce;
  logic [15:0] d0;
  logic        v0;
  logic        rdy0;
  logic [1:0]  oq0;
  logic        tq0;
  logic        busy0;
  logic        ur0;
  logic [7:0]  d1;
  logic        v1;
  logic        rdy1;
  logic [0:0]  oq1;
  logic        tq1;
  logic        busy1;
  logic        ur1;

  int checks = 0;
  int errors = 0;

  x_oserdes_gen #(
    .DATA_WIDTH(DW), .LANES(2), .MSB_FIRST(1'b0),
    .INIT_OQ(1'b0), .SRVAL_TQ(1'b1), .TRISTATE_EN(1'b1)
  ) dut0 (
    .CLK(clk), .SR(sr), .D(d0), .D_VALID(v0), .D_READY(rdy0), .OCE(oce),
    .OQ(oq0), .TQ(tq0), .BUSY(busy0), .UNDERRUN(ur0)
  );

  x_oserdes_gen #(
    .DATA_WIDTH(DW), .LANES(1), .MSB_FIRST(1'b1),
    .INIT_OQ(1'b0), .SRVAL_TQ(1'b1), .TRISTATE_EN(1'b1)
  ) dut1 (
    .CLK(clk), .SR(sr), .D(d1), .D_VALID(v1), .D_READY(rdy1), .OCE(oce),
    .OQ(oq1), .TQ(tq1), .BUSY(busy1), .UNDERRUN(ur1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [15:0] w);
    d0 = w;
    v0 = 1'b1;
    step();
    v0 = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Power-on reset state, seen before any clock edge.
  task automatic test_reset();
    logic [5:0] got;
    #1;
    got = {oq0, tq0, rdy0, busy0, ur0};
    checks++;
    if (got !== 6'b00_1_1_0_0) begin
      errors++;
      $display("FAIL reset_dut0 got %b expected %b", got, 6'b001100);
    end
    got = {1'b0, oq1, tq1, rdy1, busy1, ur1};
    checks++;
    if (got !== 6'b0_0_1_1_0_0) begin
      errors++;
      $display("FAIL reset_dut1 got %b expected %b", got, 6'b001100);
    end
    step();
    step();
    sr = 1'b0;
    step();
    got = {oq0, tq0, rdy0, busy0, ur0};
    checks++;
    if (got !== 6'b00_1_1_0_0) begin
      errors++;
      $display("FAIL idle_after_release got %b expected %b", got, 6'b001100);
    end
  endtask

  // 8'hA5 LSB first on lane 0, then underrun at the boundary.
  task automatic test_single_word();
    logic [7:0] a;
    logic [3:0] got;
    logic [3:0] exp;
    a = 8'hA5;
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_pre got %b expected 1", rdy0);
    end
    send0({8'h00, a});
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_full got %b expected 0", rdy0);
    end
    for (int i = 0; i < DW; i++) begin
      step();
      got = {oq0[0], tq0, busy0, ur0};
      exp = {a[i], 1'b0, 1'b1, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_bit%0d got %b expected %b", i, got, exp);
      end
      if (i == 0) begin
        checks++;
        if (rdy0 !== 1'b1) begin
          errors++;
          $display("FAIL single_ready_after_load got %b expected 1", rdy0);
        end
      end
    end
    step();
    got = {oq0[0], tq0, busy0, ur0};
    checks++;
    if (got !== 4'b0_1_0_1) begin
      errors++;
      $display("FAIL single_end got %b expected %b", got, 4'b0101);
    end
    step();
    checks++;
    if (ur0 !== 1'b0) begin
      errors++;
      $display("FAIL single_ur_pulse got %b expected 0", ur0);
    end
  endtask

  // Two lanes serialize their own bytes on identical cycles.
  task automatic test_multi_lane();
    logic [7:0] l0;
    logic [7:0] l1;
    logic [2:0] got;
    logic [2:0] exp;
    l0 = 8'h81;
    l1 = 8'h3C;
    send0({l1, l0});
    for (int i = 0; i < DW; i++) begin
      step();
      got = {oq0, tq0};
      exp = {l1[i], l0[i], 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL multi_lane_bit%0d got %b expected %b", i, got, exp);
      end
    end
    drain(3);
  endtask

  // MSB-first stream of F0 then 0F with D_VALID held: 16 contiguous bits.
  task automatic test_back_to_back();
    logic [7:0]  words [0:1];
    logic [15:0] seq;
    logic [2:0]  got;
    logic [2:0]  exp;
    int idx;
    int first;
    logic acc;
    words[0] = 8'hF0;
    words[1] = 8'h0F;
    seq = 16'b1111000000001111;
    idx = 0;
    first = -1;
    for (int k = 0; k < 20; k++) begin
      if (idx < 2) begin
        d1 = words[idx];
        v1 = 1'b1;
      end else begin
        v1 = 1'b0;
      end
      acc = v1 && rdy1;
      step();
      if (acc) begin
        if (idx == 0) first = k;
        idx++;
      end
      if (first >= 0 && k > first && k <= first + 16) begin
        got = {oq1[0], tq1, ur1};
        exp = {seq[15 - (k - first - 1)], 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL b2b_bit%0d got %b expected %b", k - first - 1, got, exp);
        end
      end else if (first >= 0 && k == first + 17) begin
        got = {oq1[0], tq1, ur1};
        checks++;
        if (got !== 3'b0_1_1) begin
          errors++;
          $display("FAIL b2b_end got %b expected %b", got, 3'b011);
        end
      end
    end
    v1 = 1'b0;
    checks++;
    if (idx !== 2) begin
      errors++;
      $display("FAIL b2b_accepts got %0d expected 2", idx);
    end
    drain(2);
  endtask

  // OCE low for 3 edges after bit 3: word lasts 11 cycles; dut1 accepts
  // into holding while frozen and loads only once OCE returns.
  task automatic test_oce_freeze();
    logic [7:0] a;
    logic [3:0] got;
    logic [3:0] exp;
    int bi;
    a = 8'hA5;
    send0({8'h00, a});
    for (int k = 1; k <= 12; k++) begin
      oce = (k >= 5 && k <= 7) ? 1'b0 : 1'b1;
      if (k == 5) begin
        checks++;
        if (rdy1 !== 1'b1) begin
          errors++;
          $display("FAIL freeze_rdy1_pre got %b expected 1", rdy1);
        end
        d1 = 8'h80;
        v1 = 1'b1;
      end else begin
        v1 = 1'b0;
      end
      step();
      if (k <= 11) begin
        bi = (k <= 4) ? k - 1 : ((k <= 7) ? 3 : k - 4);
        got = {oq0[0], tq0, busy0, ur0};
        exp = {a[bi], 1'b0, 1'b1, 1'b0};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL freeze_cycle%0d got %b expected %b", k, got, exp);
        end
      end else begin
        got = {oq0[0], tq0, busy0, ur0};
        checks++;
        if (got !== 4'b0_1_0_1) begin
          errors++;
          $display("FAIL freeze_end got %b expected %b", got, 4'b0101);
        end
      end
      if (k >= 5 && k <= 7) begin
        got = {1'b0, rdy1, tq1, busy1};
        checks++;
        if (got !== 4'b0_0_1_0) begin
          errors++;
          $display("FAIL freeze_hold_dut1 cycle%0d got %b expected %b", k, got, 4'b0010);
        end
      end else if (k == 8) begin
        got = {oq1[0], tq1, busy1, rdy1};
        checks++;
        if (got !== 4'b1_0_1_1) begin
          errors++;
          $display("FAIL freeze_load_dut1 got %b expected %b", got, 4'b1011);
        end
      end
    end
    oce = 1'b1;
    v1 = 1'b0;
    drain(12);
  endtask

  // Word accepted on the boundary edge: underrun, one idle cycle, then start.
  task automatic test_late_word();
    logic [7:0] b;
    logic [4:0] got;
    logic [3:0] g4;
    b = 8'h6B;
    send0({8'h00, 8'hA5});
    drain(DW);
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL late_ready got %b expected 1", rdy0);
    end
    send0({8'h00, b});
    got = {tq0, busy0, ur0, rdy0, oq0[0]};
    checks++;
    if (got !== 5'b1_0_1_0_0) begin
      errors++;
      $display("FAIL late_boundary got %b expected %b", got, 5'b10100);
    end
    for (int i = 0; i < DW; i++) begin
      step();
      g4 = {oq0[0], tq0, busy0, ur0};
      checks++;
      if (g4 !== {b[i], 3'b0_1_0}) begin
        errors++;
        $display("FAIL late_bit%0d got %b expected %b", i, g4, {b[i], 3'b010});
      end
    end
    drain(3);
  endtask

  // Asynchronous reset during bit 5 with a word held: both discarded.
  task automatic test_reset_async();
    logic [7:0] a;
    logic [7:0] l0;
    logic [7:0] l1;
    logic [5:0] got;
    logic [2:0] g3;
    a = 8'hA5;
    l0 = 8'h3C;
    l1 = 8'h5A;
    send0({8'h11, a});
    step();
    send0({8'h22, 8'hFF});
    drain(4);
    checks++;
    if (oq0[0] !== a[5]) begin
      errors++;
      $display("FAIL rst_pre_bit5 got %b expected %b", oq0[0], a[5]);
    end
    #2;
    sr = 1'b1;
    #1;
    got = {oq0, tq0, rdy0, busy0, ur0};
    checks++;
    if (got !== 6'b00_1_1_0_0) begin
      errors++;
      $display("FAIL rst_async_dut0 got %b expected %b", got, 6'b001100);
    end
    got = {1'b0, oq1, tq1, rdy1, busy1, ur1};
    checks++;
    if (got !== 6'b0_0_1_1_0_0) begin
      errors++;
      $display("FAIL rst_async_dut1 got %b expected %b", got, 6'b001100);
    end
    step();
    sr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      got = {oq0, tq0, rdy0, busy0, ur0};
      checks++;
      if (got !== 6'b00_1_1_0_0) begin
        errors++;
        $display("FAIL rst_no_remnant cycle%0d got %b expected %b", i, got, 6'b001100);
      end
    end
    send0({l1, l0});
    for (int i = 0; i < DW; i++) begin
      step();
      g3 = {oq0, tq0};
      checks++;
      if (g3 !== {l1[i], l0[i], 1'b0}) begin
        errors++;
        $display("FAIL rst_new_word_bit%0d got %b expected %b", i, g3, {l1[i], l0[i], 1'b0});
      end
    end
    drain(3);
  endtask

  // Random words and gaps; expected timeline comes from word start times:
  // a word accepted at edge k starts at max(k+1, previous start + DW).
  task automatic test_random();
    logic [1:0]  e_oq0  [0:NCYC+19];
    logic        e_oq1  [0:NCYC+19];
    logic        e_busy [0:NCYC+19];
    logic        e_ur   [0:NCYC+19];
    logic [15:0] w0;
    logic [7:0]  w1;
    logic        vv;
    logic        m_ready;
    logic [4:0]  got;
    logic [4:0]  exp;
    logic [1:0]  gr;
    int last_s;
    int s;
    bit have_prev;
    int nacc;
    for (int i = 0; i < NCYC + 20; i++) begin
      e_oq0[i] = 2'b00;
      e_oq1[i] = 1'b0;
      e_busy[i] = 1'b0;
      e_ur[i] = 1'b0;
    end
    have_prev = 1'b0;
    last_s = 0;
    nacc = 0;
    for (int k = 0; k < NCYC; k++) begin
      m_ready = !(have_prev && last_s >= k);
      gr = {rdy0, rdy1};
      checks++;
      if (gr !== {m_ready, m_ready}) begin
        errors++;
        $display("FAIL rand_ready edge%0d got %b expected %b", k, gr, {m_ready, m_ready});
      end
      vv = (k < NDRV) ? ($urandom_range(0, 9) < 4) : 1'b0;
      w0 = 16'($urandom);
      w1 = 8'($urandom);
      d0 = w0;
      d1 = w1;
      v0 = vv;
      v1 = vv;
      step();
      if (vv && m_ready) begin
        s = k + 1;
        if (have_prev && (last_s + DW) > s) s = last_s + DW;
        if (have_prev && s == last_s + DW) e_ur[last_s + DW] = 1'b0;
        for (int j = 0; j < DW; j++) begin
          e_busy[s + j] = 1'b1;
          e_oq0[s + j] = {w0[8 + j], w0[j]};
          e_oq1[s + j] = w1[DW - 1 - j];
        end
        e_ur[s + DW] = 1'b1;
        last_s = s;
        have_prev = 1'b1;
        nacc++;
      end
      got = {oq0, tq0, busy0, ur0};
      exp = {e_oq0[k], ~e_busy[k], e_busy[k], e_ur[k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rand_dut0 edge%0d got %b expected %b", k, got, exp);
      end
      got = {1'b0, oq1, tq1, busy1, ur1};
      exp = {1'b0, e_oq1[k], ~e_busy[k], e_busy[k], e_ur[k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rand_dut1 edge%0d got %b expected %b", k, got, exp);
      end
    end
    v0 = 1'b0;
    v1 = 1'b0;
    checks++;
    if (nacc < 10) begin
      errors++;
      $display("FAIL rand_accepts got %0d expected at least 10", nacc);
    end
  endtask

  initial begin
    clk = 1'b0;
    sr  = 1'b1;
    oce = 1'b1;
    d0  = '0;
    v0  = 1'b0;
    d1  = '0;
    v1  = 1'b0;
    test_reset();
    test_single_word();
    test_multi_lane();
    test_back_to_back();
    test_oce_freeze();
    test_late_word();
    test_reset_async();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/x_oserdes_gen.md
Name: x_oserdes_gen

Overview:
- Single-clock, parametrised output serializer; the next generation of the X_OSERDES simprim family.
- Accepts LANES parallel words of DATA_WIDTH bits through a valid/ready handshake and shifts them out SDR, one bit per lane per CLK.
- Double-buffered (holding + shift register) so back-to-back words stream with no gap.
- Drives per-lane OQ plus a shared tristate TQ that releases the pad when idle; flags underruns.

Parameters:
- DATA_WIDTH, 8, bits per word per lane; legal 2..16
- LANES, 1, number of parallel output lanes sharing one control path; legal 1..8
- MSB_FIRST, 0, 1 = bit DATA_WIDTH-1 serialized first; 0 = bit 0 first
- INIT_OQ, 1'b0, OQ value while idle and after reset
- SRVAL_TQ, 1'b1, TQ value while idle and after reset (1 = high-Z)
- TRISTATE_EN, 1, 0 = TQ forced 0 permanently

Ports:
- CLK  input  1  serial bit clock; all state on rising edge
- SR  input  1  asynchronous, active-high reset
- D  input  LANES*DATA_WIDTH  parallel data; lane i = D[i*DATA_WIDTH +: DATA_WIDTH]
- D_VALID  input  1  D holds a word for all lanes
- D_READY  output  1  holding register empty; transfer when D_VALID & D_READY at a rising edge
- OCE  input  1  output clock enable; 0 freezes the shift path
- OQ  output  LANES  registered serial data, one bit per lane
- TQ  output  1  registered tristate control, shared by all lanes
- BUSY  output  1  shifter active
- UNDERRUN  output  1  one-cycle pulse: stream broke at a word boundary

Behaviour:
- Reset (SR=1, asynchronous):
  - OQ = {LANES{INIT_OQ}}; TQ = TRISTATE_EN ? SRVAL_TQ : 0.
  - Holding empty, so D_READY = 1.
  - BUSY = 0, UNDERRUN = 0, bit counter = 0.
  - SR asserted mid-word aborts the word and discards the holding word. No partial word resumes after release.
- D_READY = !hold_full, combinational from state only; never depends on D_VALID.
- Accept: at an edge with D_VALID & D_READY, D is captured into holding and hold_full is set.
- Shift path is evaluated only when OCE = 1. With OCE = 0:
  - OQ, TQ, counter, shift register and BUSY hold their values; UNDERRUN = 0.
  - The holding register still accepts a word.
- States: IDLE (BUSY = 0), SHIFT (BUSY = 1).
- IDLE:
  - If hold_full, at that edge: load the shifter, drive the first bit onto OQ, set TQ = 0, counter = 1, go to SHIFT, clear hold_full (D_READY = 1 next cycle).
  - A word accepted at edge N appears on OQ after edge N+1.
- SHIFT, counter < DATA_WIDTH: OQ = next bit (order per MSB_FIRST), counter + 1.
- SHIFT, counter == DATA_WIDTH (last bit currently on OQ):
  - If hold_full: reload exactly as in IDLE, so the next word's first bit follows with zero gap.
  - Else: OQ = INIT_OQ, TQ = SRVAL_TQ (gated by TRISTATE_EN), go to IDLE, UNDERRUN = 1 for one cycle.
- Simultaneous accept and reload at one edge cannot occur: accept requires hold_full = 0, reload requires hold_full = 1. A word accepted at the boundary edge itself misses that boundary, and UNDERRUN fires.
- Throughput: sustained 1 word per DATA_WIDTH cycles. D_VALID held with D_READY returning 1 yields a continuous stream.
- All lanes share the counter, shift timing and TQ; lanes differ only in data.
- Outputs are registered (no combinational path D to OQ) except D_READY.

Test Plan:
- Reset, idle: assert SR mid-simulation asynchronously, with DATA_WIDTH=8, INIT_OQ=0 -> OQ=0, TQ=1, D_READY=1, BUSY=0 immediately, without a clock edge.
- Single word, LSB first: DATA_WIDTH=8, LANES=1, MSB_FIRST=0, accept D=8'hA5 at edge N.
  - OQ after edges N+1..N+8 = 1,0,1,0,0,1,0,1; TQ=0 for exactly those 8 cycles.
  - Edge N+9 -> OQ=0, TQ=1, UNDERRUN pulse.
- Back-to-back streaming: MSB_FIRST=1, words 8'hF0 then 8'h0F, D_VALID held -> 16 contiguous bits 1111000000001111, TQ stays 0 throughout, no UNDERRUN between the words.
- Multi-lane: LANES=2, D=16'h3C_81 -> lane0 serializes 8'h81, lane1 serializes 8'h3C, on identical cycles.
- OCE freeze: deassert OCE for 3 cycles after bit 3 of 8'hA5 -> OQ holds bit 3 value for 4 cycles total, then resumes at bit 4; total word duration 11 cycles.
- Reset mid-word plus late word:
  - SR pulsed during bit 5 -> next word after release starts at bit 0; no remnant bits appear.
  - Separately, a word accepted on the final-bit edge -> UNDERRUN pulse, then one idle cycle (TQ=1), then the word starts.
